// File: rtl/max_in_n_datas_seq.sv
// Sequential max-finder: scans LANES masked scores per cycle and reports the largest with a one-hot index.
// Optional binary index output index_bin_o is enabled by defining MAX_IN_DATAS_BIN_INDEX_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | ready for start_i; results hold their last completed value
//   SCAN    | one chunk of LANES entries compared against the running best per edge
//   DONE    | results just updated; done_o pulses for this single cycle
module max_in_n_datas_seq #(
    parameter int NUM   = 16,
    parameter int WIDTH = 5,
    parameter int LANES = 4,
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [NUM*WIDTH-1:0]   data_i,
    input  logic [NUM-1:0]         mask_i,
    output logic                   ready_o,
    output logic                   done_o,
    output logic                   found_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [NUM-1:0]         index_o
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
    ,
    output logic [IDX_W-1:0]       index_bin_o
`endif
);

    localparam int CHUNKS = NUM / LANES;
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM*WIDTH-1:0]   shadow_data_q, shadow_data_d;
    logic [NUM-1:0]         shadow_mask_q, shadow_mask_d;

    logic                   best_found_q, best_found_d;
    logic [WIDTH-1:0]       best_val_q, best_val_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;

    logic                   res_found_q, res_found_d;
    logic [WIDTH-1:0]       res_data_q, res_data_d;
    logic [NUM-1:0]         res_index_q, res_index_d;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
    logic [IDX_W-1:0]       res_bin_q, res_bin_d;
`endif

    logic [WIDTH-1:0]       score [NUM];
    logic                   cand_found;
    logic [WIDTH-1:0]       cand_val;
    logic [IDX_W-1:0]       cand_idx;
    logic [IDX_W-1:0]       pos;
    logic                   last_chunk;

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            score[k] = shadow_data_q[k*WIDTH +: WIDTH];
        end
    end

    // Lanes are visited in ascending order with a strict '>' so the lowest index wins every tie,
    // both inside a chunk and against the best carried from earlier chunks.
    always_comb begin
        cand_found = best_found_q;
        cand_val   = best_val_q;
        cand_idx   = best_idx_q;
        pos        = '0;
        for (int l = 0; l < LANES; l++) begin
            pos = IDX_W'(int'(cnt_q) * LANES + l);
            if (shadow_mask_q[pos] && (!cand_found || (score[pos] > cand_val))) begin
                cand_found = 1'b1;
                cand_val   = score[pos];
                cand_idx   = pos;
            end
        end
    end

    assign last_chunk = (cnt_q == CNT_W'(CHUNKS - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        best_found_d  = best_found_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        res_found_d   = res_found_q;
        res_data_d    = res_data_q;
        res_index_d   = res_index_q;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        res_bin_d     = res_bin_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    shadow_data_d = data_i;
                    shadow_mask_d = mask_i;
                    best_found_d  = 1'b0;
                    best_val_d    = '0;
                    best_idx_d    = '0;
                    cnt_d         = '0;
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    best_found_d = cand_found;
                    best_val_d   = cand_val;
                    best_idx_d   = cand_idx;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (last_chunk) begin
                        state_d     = ST_DONE;
                        res_found_d = cand_found;
                        res_data_d  = cand_found ? cand_val : '0;
                        res_index_d = cand_found ? (NUM'(1) << cand_idx) : '0;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
                        res_bin_d   = cand_found ? cand_idx : '0;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
            best_found_q  <= 1'b0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            res_found_q   <= 1'b0;
            res_data_q    <= '0;
            res_index_q   <= '0;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
            res_bin_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            best_found_q  <= best_found_d;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            res_found_q   <= res_found_d;
            res_data_q    <= res_data_d;
            res_index_q   <= res_index_d;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
            res_bin_q     <= res_bin_d;
`endif
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign found_o = res_found_q;
    assign data_o  = res_data_q;
    assign index_o = res_index_q;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
    assign index_bin_o = res_bin_q;
`endif

endmodule

// File: tb/tb_max_in_n_datas_seq.sv
// Directed bench for max_in_n_datas_seq (NUM=16, WIDTH=5; LANES=4 and LANES=16 instances).
// Binary-index checks are active when MAX_IN_DATAS_BIN_INDEX_EN is defined.
module tb_max_in_n_datas_seq;
    localparam int NUM   = 16;
    localparam int WIDTH = 5;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, start2;
    logic [NUM*WIDTH-1:0] din;
    logic [NUM-1:0]       min;

    logic ready, done, found;
    logic [WIDTH-1:0] dout;
    logic [NUM-1:0]   idx;
    logic ready2, done2, found2;
    logic [WIDTH-1:0] dout2;
    logic [NUM-1:0]   idx2;
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
    logic [IDX_W-1:0] bin, bin2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    max_in_n_datas_seq #(.NUM(NUM), .WIDTH(WIDTH), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .data_i(din), .mask_i(min), .ready_o(ready), .done_o(done),
        .found_o(found), .data_o(dout), .index_o(idx)
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        , .index_bin_o(bin)
`endif
    );

    max_in_n_datas_seq #(.NUM(NUM), .WIDTH(WIDTH), .LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(1'b0),
        .data_i(din), .mask_i(min), .ready_o(ready2), .done_o(done2),
        .found_o(found2), .data_o(dout2), .index_o(idx2)
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        , .index_bin_o(bin2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [NUM*WIDTH-1:0] fill(input logic [WIDTH-1:0] v);
        logic [NUM*WIDTH-1:0] r;
        for (int k = 0; k < NUM; k++) r[k*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    function automatic logic [NUM*WIDTH-1:0] put(input logic [NUM*WIDTH-1:0] v, input int k,
                                                 input logic [WIDTH-1:0] s);
        logic [NUM*WIDTH-1:0] r;
        r = v;
        r[k*WIDTH +: WIDTH] = s;
        return r;
    endfunction

    // Accepts a scan, scrambles the inputs afterwards, and waits (bounded) for done.
    task automatic scan(input logic [NUM*WIDTH-1:0] d, input logic [NUM-1:0] m, output int lat);
        din   = d;
        min   = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        din   = ~d;
        min   = ~m;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [NUM*WIDTH-1:0] d;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        din = '0; min = '0;
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done",  done,  1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_data",  dout,  5'd0);
        chk("rst_index", idx,   16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ascending scores, all eligible
        d = '0;
        for (int k = 0; k < NUM; k++) d = put(d, k, 5'(k + 1));
        scan(d, 16'hFFFF, lat);
        chk("asc_latency", lat, 4);
        chk("asc_found", found, 1'b1);
        chk("asc_data",  dout,  5'd16);
        chk("asc_index", idx,   16'h8000);
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        chk("asc_bin", bin, 4'd15);
`endif
        tick();
        chk("asc_done_drop", done,  1'b0);
        chk("asc_ready",     ready, 1'b1);

        // tie across chunks: earlier chunk kept
        scan(put(put(fill(5'd5), 3, 5'd31), 9, 5'd31), 16'hFFFF, lat);
        chk("tie_x_data",  dout, 5'd31);
        chk("tie_x_index", idx,  16'h0008);
        tick();

        // tie within one chunk: lowest lane wins; start during DONE is ignored
        scan(put(put(fill(5'd5), 1, 5'd31), 2, 5'd31), 16'hFFFF, lat);
        chk("tie_in_data",  dout, 5'd31);
        chk("tie_in_index", idx,  16'h0002);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", ready, 1'b1);

        // tie at chunk boundary entries 4 and 8
        scan(put(put(fill(5'd0), 4, 5'd10), 8, 5'd10), 16'hFFFF, lat);
        chk("tie_b_index", idx, 16'h0010);
        tick();

        // masked-out maximum
        scan(put(put(fill(5'd0), 15, 5'd31), 7, 5'd20), 16'h7FFF, lat);
        chk("mask_data",  dout, 5'd20);
        chk("mask_index", idx,  16'h0080);
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        chk("mask_bin", bin, 4'd7);
`endif
        tick();

        // nothing eligible
        scan(fill(5'd9), 16'h0000, lat);
        chk("none_found", found, 1'b0);
        chk("none_data",  dout,  5'd0);
        chk("none_index", idx,   16'h0000);
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        chk("none_bin", bin, 4'd0);
`endif
        tick();

        // eligible zero beats "none"
        scan(fill(5'd0), 16'h0020, lat);
        chk("zero_found", found, 1'b1);
        chk("zero_data",  dout,  5'd0);
        chk("zero_index", idx,   16'h0020);
        tick();

        // abort in the 2nd SCAN cycle keeps prior result 12
        scan(put(fill(5'd0), 6, 5'd12), 16'hFFFF, lat);
        chk("pre_abort_data", dout, 5'd12);
        tick();
        din = put(fill(5'd0), 0, 5'd30);
        min = 16'hFFFF;
        start = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        tick();
        chk("abort_ready", ready, 1'b1);
        chk("abort_done",  done,  1'b0);
        chk("abort_data",  dout,  5'd12);
        chk("abort_index", idx,   16'h0040);
        start = 1'b0;
        abort = 1'b0;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_hold_data", dout, 5'd12);

        // reset mid-scan clears everything immediately
        din = fill(5'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done",  done,  1'b0);
        chk("midrst_found", found, 1'b0);
        chk("midrst_data",  dout,  5'd0);
        chk("midrst_index", idx,   16'h0000);
        #2;
        rst_n = 1'b1;
        tick();

        // single-chunk instance: done one cycle after accept
        d = '0;
        for (int k = 0; k < NUM; k++) d = put(d, k, 5'(k + 1));
        din = d;
        min = 16'hFFFF;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("l16_accept_done", done2, 1'b0);
        tick();
        chk("l16_done",  done2, 1'b1);
        chk("l16_data",  dout2, 5'd16);
        chk("l16_index", idx2,  16'h8000);
`ifdef MAX_IN_DATAS_BIN_INDEX_EN
        chk("l16_bin", bin2, 4'd15);
`endif
        tick();
        chk("l16_ready", ready2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
